pipelined_rca_adder: RTL and testbench

PIPELINED_RCA_ADDER -- requirements
Module: pipelined_rca_adder

---
 rtl/pipelined_rca_adder.sv | 166 ++++++++++++++++
 tb/tb_pipelined_rca_adder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split into SEG-bit ripple segments, one segment per stage.
// Latency: STAGES = WIDTH/SEG cycles from accepted beat to out_valid; one beat per cycle.
// Backpressure: every register freezes while out_valid && !out_ready; in_ready drops combinationally.
//
// Ports: clk, rst_n (async active-low); A, B, C_in, in_valid -> in_ready (input handshake);
//        S, C_out, out_valid <- out_ready (output handshake); V (signed overflow) only when
//        RCA_OVERFLOW_EN is defined.
// Operand segment k is skewed by k cycles so it meets its carry from stage k-1; sum segment k
// is de-skewed by STAGES-1-k cycles so a whole result leaves in a single cycle.
module pipelined_rca_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
`ifdef RCA_OVERFLOW_EN
    output logic             V,
`endif
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SEG_SAFE = (SEG >= 1) ? SEG : 1;
    localparam bit CFG_OK   = (SEG >= 1) && (WIDTH >= SEG_SAFE) && ((WIDTH % SEG_SAFE) == 0);
    localparam int STAGES   = WIDTH / SEG_SAFE;

    if (!CFG_OK) begin : g_bad_cfg
        $error("pipelined_rca_adder: WIDTH must be a positive multiple of SEG, and SEG >= 1");
    end

    // Single shared enable: the pipeline moves only when the output slot is free or draining.
    logic advance;

    logic [STAGES-1:0] stg_cy;
    logic [STAGES-1:0] stg_vld;

    assign out_valid = stg_vld[STAGES-1];
    assign C_out     = stg_cy[STAGES-1];
    assign in_ready  = !(out_valid && !out_ready);
    assign advance   = in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DSK = STAGES - 1 - k;

        logic [SEG-1:0] a_op;
        logic [SEG-1:0] b_op;
        logic           cin;
        logic           vld_d;
        logic [SEG:0]   rc;
        logic [SEG-1:0] sum_d;
        logic           cy_d;
        logic [SEG-1:0] sum_q;
        logic           cy_q;
        logic           vld_q;

        if (k == 0) begin : g_first
            assign a_op  = A[SEG-1:0];
            assign b_op  = B[SEG-1:0];
            assign cin   = C_in;
            assign vld_d = in_valid;
        end else begin : g_skew
            // Segment k of the operands waits k cycles for its carry to be produced.
            logic [SEG-1:0] a_dly_q [k];
            logic [SEG-1:0] b_dly_q [k];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < k; j++) begin
                        a_dly_q[j] <= '0;
                        b_dly_q[j] <= '0;
                    end
                end else if (advance) begin
                    a_dly_q[0] <= A[k*SEG +: SEG];
                    b_dly_q[0] <= B[k*SEG +: SEG];
                    for (int j = 1; j < k; j++) begin
                        a_dly_q[j] <= a_dly_q[j-1];
                        b_dly_q[j] <= b_dly_q[j-1];
                    end
                end
            end

            assign a_op  = a_dly_q[k-1];
            assign b_op  = b_dly_q[k-1];
            assign cin   = stg_cy[k-1];
            assign vld_d = stg_vld[k-1];
        end

        // Bit-serial ripple chain across this segment; rc[i] is the carry into bit i.
        always_comb begin
            rc    = '0;
            sum_d = '0;
            rc[0] = cin;
            for (int i = 0; i < SEG; i++) begin
                sum_d[i] = a_op[i] ^ b_op[i] ^ rc[i];
                rc[i+1]  = (a_op[i] & b_op[i]) | (rc[i] & (a_op[i] ^ b_op[i]));
            end
        end

        assign cy_d = rc[SEG];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
                cy_q  <= 1'b0;
                vld_q <= 1'b0;
            end else if (advance) begin
                sum_q <= sum_d;
                cy_q  <= cy_d;
                vld_q <= vld_d;
            end
        end

        assign stg_cy[k]  = cy_q;
        assign stg_vld[k] = vld_q;

        if (DSK == 0) begin : g_out_seg
            assign S[k*SEG +: SEG] = sum_q;
        end else begin : g_deskew
            // Early segments wait here until the top segment of the same beat is ready.
            logic [SEG-1:0] s_dly_q [DSK];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < DSK; j++) begin
                        s_dly_q[j] <= '0;
                    end
                end else if (advance) begin
                    s_dly_q[0] <= sum_q;
                    for (int j = 1; j < DSK; j++) begin
                        s_dly_q[j] <= s_dly_q[j-1];
                    end
                end
            end

            assign S[k*SEG +: SEG] = s_dly_q[DSK-1];
        end

`ifdef RCA_OVERFLOW_EN
        if (k == STAGES - 1) begin : g_ovf
            // Signed overflow: carry into the MSB disagrees with carry out of the MSB.
            logic v_d;
            logic v_q;

            assign v_d = rc[SEG] ^ rc[SEG-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                end else if (advance) begin
                    v_q <= v_d;
                end
            end

            assign V = v_q;
        end
`endif
    end

endmodule

// File: tb/tb_pipelined_rca_adder.sv
module tb_pipelined_rca_adder;

    localparam int W  = 16;
    localparam int SG = 4;
    localparam int ST = W / SG;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;

    // Main instance: WIDTH=16, SEG=4
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s;
    logic         c_out;
    logic         out_valid;
    logic         out_ready;
`ifdef RCA_OVERFLOW_EN
    logic         v;
`endif

    // Second instance: WIDTH=4, SEG=4 (single stage)
    logic [3:0]   a2;
    logic [3:0]   b2;
    logic         cin2;
    logic         iv2;
    logic         ir2;
    logic [3:0]   s2;
    logic         co2;
    logic         ov2;
    logic         or2;
`ifdef RCA_OVERFLOW_EN
    logic         v2;
`endif

    always #5 clk = ~clk;

    pipelined_rca_adder #(.WIDTH(W), .SEG(SG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a),
        .B         (b),
        .C_in      (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (s),
        .C_out     (c_out),
`ifdef RCA_OVERFLOW_EN
        .V         (v),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    pipelined_rca_adder #(.WIDTH(4), .SEG(4)) dut_w4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a2),
        .B         (b2),
        .C_in      (cin2),
        .in_valid  (iv2),
        .in_ready  (ir2),
        .S         (s2),
        .C_out     (co2),
`ifdef RCA_OVERFLOW_EN
        .V         (v2),
`endif
        .out_valid (ov2),
        .out_ready (or2)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // ---------------- Reference model ----------------
    // Transaction-level latency line: each slot holds a whole beat's arithmetic result.
    logic         m_vld [ST];
    logic [W:0]   m_res [ST];
`ifdef RCA_OVERFLOW_EN
    logic         m_ovf [ST];

    function automatic logic ovf_of(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int sum;
        sum = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (sum > (2 ** (W - 1)) - 1) || (sum < -(2 ** (W - 1)));
    endfunction
`endif

    int acc_cnt = 0;
    int del_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ST; i++) m_vld[i] = 1'b0;
            acc_cnt = 0;
            del_cnt = 0;
        end else begin
            if (out_valid && out_ready) del_cnt++;
            if (!(m_vld[ST-1] && !out_ready)) begin
                if (in_valid) acc_cnt++;
                for (int i = ST - 1; i > 0; i--) begin
                    m_vld[i] = m_vld[i-1];
                    m_res[i] = m_res[i-1];
`ifdef RCA_OVERFLOW_EN
                    m_ovf[i] = m_ovf[i-1];
`endif
                end
                m_vld[0] = in_valid;
                m_res[0] = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
`ifdef RCA_OVERFLOW_EN
                m_ovf[0] = ovf_of(a, b, cin);
`endif
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(!(m_vld[ST-1] && !out_ready)));
        chk("out_valid", 32'(out_valid), 32'(m_vld[ST-1]));
        if (m_vld[ST-1]) begin
            chk("sum", 32'({c_out, s}), 32'(m_res[ST-1]));
`ifdef RCA_OVERFLOW_EN
            chk("ovf", 32'(v), 32'(m_ovf[ST-1]));
`endif
        end
    end

    // ---------------- Stimulus ----------------
    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic vl);
        a        = x;
        b        = y;
        cin      = c;
        in_valid = vl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive('0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            2:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [3:0] x4;
        logic [3:0] y4;
        logic       c4;

        a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a2 = '0; b2 = '0; cin2 = 1'b0; iv2 = 1'b0; or2 = 1'b1;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'({c_out, s}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Beat presented right after release; carry ripples through all four stages
        rst_n = 1'b1;
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        idle();
        idle();
        chk("lat_not_early", 32'(out_valid), 32'd0);
        idle();
        chk("carry_all_stages", 32'({out_valid, c_out, s}), 32'({1'b1, 1'b1, 16'h0000}));
        idle();

        // Back-to-back beats emerge consecutively in order
        drive(16'h0001, 16'h0002, 1'b0, 1'b1);
        drive(16'h00FF, 16'h0F01, 1'b1, 1'b1);
        drive(16'h8000, 16'h8000, 1'b0, 1'b1);
        idle();
        chk("b2b_0", 32'({out_valid, c_out, s}), 32'({1'b1, 1'b0, 16'h0003}));
        idle();
        chk("b2b_1", 32'({out_valid, c_out, s}), 32'({1'b1, 1'b0, 16'h1001}));
        idle();
        chk("b2b_2", 32'({out_valid, c_out, s}), 32'({1'b1, 1'b1, 16'h0000}));
        repeat (3) idle();

`ifdef RCA_OVERFLOW_EN
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        idle();
        idle();
        chk("ovf_pos", 32'({v, s}), 32'({1'b1, 16'h8000}));
        idle();
        chk("ovf_none", 32'({v, c_out, s}), 32'({1'b0, 1'b1, 16'h0000}));
        repeat (3) idle();
`endif

        // Output stall for 5 cycles with a valid result and a pending input beat
        drive(16'h1234, 16'h1111, 1'b0, 1'b1);
        drive(16'h0F0F, 16'h0101, 1'b1, 1'b1);
        drive(16'hAAAA, 16'h5555, 1'b0, 1'b1);
        drive(16'h0001, 16'h0002, 1'b0, 1'b1);
        out_ready = 1'b0;
        a = 16'h2222; b = 16'h3333; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_hold", 32'({out_valid, c_out, s}), 32'({1'b1, 1'b0, 16'h2345}));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("release_0", 32'({out_valid, c_out, s}), 32'({1'b1, 1'b0, 16'h2345}));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("release_1", 32'({out_valid, c_out, s}), 32'({1'b1, 1'b0, 16'h1011}));
        repeat (8) idle();
        chk("stall_no_loss", 32'(del_cnt), 32'(acc_cnt));

        // Reset with three beats in flight
        drive(16'h1111, 16'h0001, 1'b0, 1'b1);
        drive(16'h2222, 16'h0001, 1'b0, 1'b1);
        drive(16'h3333, 16'h0001, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("post_rst_quiet", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        drive(16'h0042, 16'h0001, 1'b1, 1'b1);
        repeat (3) idle();
        chk("post_rst_new", 32'({out_valid, c_out, s}), 32'({1'b1, 1'b0, 16'h0044}));
        repeat (3) idle();

        // Randomized traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            a         = pick_operand();
            b         = pick_operand();
            cin       = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) idle();
        chk("rand_no_loss", 32'(del_cnt), 32'(acc_cnt));

        // Single-stage instance: registered adder of latency 1
        a2 = 4'b1010; b2 = 4'b0101; cin2 = 1'b1; iv2 = 1'b1;
        @(posedge clk);
        #1;
        iv2 = 1'b0;
        chk("w4_latency1", 32'({ov2, co2, s2}), 32'({1'b1, 1'b1, 4'b0000}));
`ifdef RCA_OVERFLOW_EN
        chk("w4_ovf", 32'(v2), 32'd0);
`endif
        for (int n = 0; n < 20; n++) begin
            x4   = 4'($urandom);
            y4   = 4'($urandom);
            c4   = 1'($urandom_range(0, 1));
            a2   = x4;
            b2   = y4;
            cin2 = c4;
            iv2  = 1'b1;
            @(posedge clk);
            #1;
            chk("w4_rand", 32'({ov2, co2, s2}), 32'({1'b1, {1'b0, x4} + {1'b0, y4} + {4'b0000, c4}}));
        end
        iv2 = 1'b0;
        @(posedge clk);
        #1;
        chk("w4_bubble", 32'(ov2), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
